// File: rtl/pattern_gen.sv
// K28.5-aligned incrementing-counter TX pattern generator for a 32-bit XCVR lane.
// Asynchronous UART controls are synchronized; an error request flips bit 0 of one data word.
module pattern_gen #(
    parameter int unsigned g_DATA_WID  = 32,
    parameter int unsigned g_ALIGN_LEN = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic                  generate_err_i,
    input  logic                  tx_ready_i,
    output logic [g_DATA_WID-1:0] tx_data_o,
    output logic [3:0]            tx_k_char_o,
    output logic                  tx_val_o,
    output logic [1:0]            state_o,
    output logic [15:0]           inj_count_o
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAlign   = 2'b01,
        StData    = 2'b10,
        StIllegal = 2'b11
    } state_e;

    localparam logic [g_DATA_WID-1:0] K28_5_WORD = g_DATA_WID'(32'h0000_00BC);
    localparam logic [g_DATA_WID-1:0] DATA_ONE   = g_DATA_WID'(1);
    localparam logic [7:0]            ALIGN_LAST = 8'(g_ALIGN_LEN - 1);

    state_e                r_state;
    logic [7:0]            r_align_cnt;
    logic [g_DATA_WID-1:0] r_data_cnt;
    logic [g_DATA_WID-1:0] r_tx_data;
    logic [3:0]            r_tx_k;
    logic                  r_tx_val;
    logic [15:0]           r_inj_cnt;

    logic r_start_d1, r_start_d2;
    logic r_clear_d1, r_clear_d2;
    logic r_err_d1, r_err_d2, r_err_d3;

    logic                  w_run;
    logic                  w_err_rise;
    logic                  w_inject;
    logic [g_DATA_WID-1:0] w_data_next;
    logic [g_DATA_WID-1:0] w_inj_mask;

    assign w_run       = r_start_d2 & tx_ready_i;
    assign w_err_rise  = r_err_d2 & ~r_err_d3;
    // Only a rise seen while DATA continues can corrupt a word; anything else is dropped.
    assign w_inject    = w_err_rise & w_run & (r_state == StData);
    assign w_data_next = r_data_cnt + DATA_ONE;
    assign w_inj_mask  = {{(g_DATA_WID-1){1'b0}}, w_inject};

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_start_d1  <= 1'b0;
            r_start_d2  <= 1'b0;
            r_clear_d1  <= 1'b0;
            r_clear_d2  <= 1'b0;
            r_err_d1    <= 1'b0;
            r_err_d2    <= 1'b0;
            r_err_d3    <= 1'b0;
            r_state     <= StIdle;
            r_align_cnt <= '0;
            r_data_cnt  <= '0;
            r_tx_data   <= K28_5_WORD;
            r_tx_k      <= 4'b0001;
            r_tx_val    <= 1'b0;
            r_inj_cnt   <= '0;
        end else begin
            r_start_d1 <= start_i;
            r_start_d2 <= r_start_d1;
            r_clear_d1 <= clear_i;
            r_clear_d2 <= r_clear_d1;
            r_err_d1   <= generate_err_i;
            r_err_d2   <= r_err_d1;
            r_err_d3   <= r_err_d2;

            if (r_clear_d2) begin
                r_inj_cnt <= '0;
            end else if (w_inject && (r_inj_cnt != 16'hFFFF)) begin
                r_inj_cnt <= r_inj_cnt + 16'd1;
            end

            if (!w_run) begin
                r_state   <= StIdle;
                r_tx_data <= K28_5_WORD;
                r_tx_k    <= 4'b0001;
                r_tx_val  <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_state     <= StAlign;
                        r_align_cnt <= '0;
                        r_tx_data   <= K28_5_WORD;
                        r_tx_k      <= 4'b0001;
                        r_tx_val    <= 1'b1;
                    end
                    StAlign: begin
                        if (r_align_cnt == ALIGN_LAST) begin
                            r_state    <= StData;
                            r_data_cnt <= DATA_ONE;
                            r_tx_data  <= DATA_ONE;
                            r_tx_k     <= 4'b0000;
                        end else begin
                            r_align_cnt <= r_align_cnt + 8'd1;
                            r_tx_data   <= K28_5_WORD;
                            r_tx_k      <= 4'b0001;
                        end
                        r_tx_val <= 1'b1;
                    end
                    StData: begin
                        // The counter never sees the injected bit, so the next word is clean.
                        r_data_cnt <= w_data_next;
                        r_tx_data  <= w_data_next ^ w_inj_mask;
                        r_tx_k     <= 4'b0000;
                        r_tx_val   <= 1'b1;
                    end
                    default: begin
                        r_state   <= StIdle;
                        r_tx_data <= K28_5_WORD;
                        r_tx_k    <= 4'b0001;
                        r_tx_val  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_data_o   = r_tx_data;
    assign tx_k_char_o = r_tx_k;
    assign tx_val_o    = r_tx_val;
    assign state_o     = r_state;
    assign inj_count_o = r_inj_cnt;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: expected words are queued ahead of the clock and
// popped one per cycle against the DUT outputs.
module tb_pattern_gen;

    localparam logic [1:0]  S_IDLE  = 2'b00;
    localparam logic [1:0]  S_ALIGN = 2'b01;
    localparam logic [1:0]  S_DATA  = 2'b10;
    localparam logic [31:0] K_WORD  = 32'h0000_00BC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        clear;
    logic        gen_err;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic        tx_val;
    logic [1:0]  state;
    logic [15:0] inj_count;

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pattern_gen #(
        .g_DATA_WID (32),
        .g_ALIGN_LEN(16)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .start_i       (start),
        .clear_i       (clear),
        .generate_err_i(gen_err),
        .tx_ready_i    (tx_ready),
        .tx_data_o     (tx_data),
        .tx_k_char_o   (tx_k),
        .tx_val_o      (tx_val),
        .state_o       (state),
        .inj_count_o   (inj_count)
    );

    task automatic push_word(input logic [1:0] st, input logic [31:0] data);
        exp_t e;
        e.st   = st;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_word(S_IDLE, K_WORD);
    endtask

    task automatic push_align(input int n);
        for (int i = 0; i < n; i++) push_word(S_ALIGN, K_WORD);
    endtask

    task automatic push_data(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) push_word(S_DATA, first + 32'(i));
    endtask

    // One clock per queued word; compare state, valid, K flags and data together.
    task automatic drain(input string tag);
        exp_t        e;
        logic [38:0] got;
        logic [38:0] want;
        int          idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            e    = exp_q.pop_front();
            got  = {state, tx_val, tx_k, tx_data};
            want = {e.st, (e.st != S_IDLE), (e.st == S_DATA) ? 4'b0000 : 4'b0001, e.data};
            total++;
            assert (got === want) else begin
                bad++;
                $error("FAIL %s[%0d] got st=%0d val=%0d k=%b data=%h exp st=%0d val=%0d k=%b data=%h",
                       tag, idx, got[38:37], got[36], got[35:32], got[31:0],
                       want[38:37], want[36], want[35:32], want[31:0]);
            end
            idx++;
        end
    endtask

    task automatic check_inj(input string tag, input logic [15:0] want);
        total++;
        assert (inj_count === want) else begin
            bad++;
            $error("FAIL %s inj_count got=%0d exp=%0d", tag, inj_count, want);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        gen_err  = 1'b0;
        tx_ready = 1'b0;

        push_idle(1);
        drain("reset");
        check_inj("reset_inj", 16'd0);

        reset_n  = 1'b1;
        tx_ready = 1'b1;
        push_idle(2);
        drain("idle_no_start");

        // Start takes two synchronizer edges before ALIGN begins.
        start = 1'b1;
        push_idle(2);
        push_align(16);
        push_data(32'h1, 32'h61);
        drain("start_seq");

        // Error request lands three words later: 0x64 goes out as 0x65.
        gen_err = 1'b1;
        push_data(32'h62, 2);
        drain("err_pre");
        check_inj("inj_before", 16'd0);
        push_word(S_DATA, 32'h65);
        drain("err_word");
        check_inj("inj_one", 16'd1);
        push_data(32'h65, 7);
        drain("err_after");
        gen_err = 1'b0;
        check_inj("inj_held", 16'd1);
        push_data(32'h6C, 3);
        drain("err_settle");

        // Clear and inject reach the core on the same edge: word corrupted, count zero.
        clear   = 1'b1;
        gen_err = 1'b1;
        push_data(32'h6F, 2);
        drain("clr_pre");
        check_inj("pre_clear", 16'd1);
        push_word(S_DATA, 32'h70);
        drain("clr_inj_word");
        check_inj("clear_wins", 16'd0);
        clear   = 1'b0;
        gen_err = 1'b0;
        push_data(32'h72, 4);
        drain("clr_after");
        check_inj("clear_hold", 16'd0);

        gen_err = 1'b1;
        push_data(32'h76, 2);
        push_word(S_DATA, 32'h79);
        drain("inj2");
        gen_err = 1'b0;
        push_data(32'h79, 3);
        drain("inj2_after");
        check_inj("inj_again", 16'd1);

        // Counter wrap through 0xFFFFFFFF.
        dut.r_data_cnt = 32'hFFFF_FFFD;
        push_word(S_DATA, 32'hFFFF_FFFE);
        push_word(S_DATA, 32'hFFFF_FFFF);
        push_data(32'h0, 3);
        drain("wrap");

        // Ready is not synchronized: one low cycle drops straight to IDLE.
        tx_ready = 1'b0;
        push_idle(1);
        drain("ready_drop");
        tx_ready = 1'b1;
        push_align(16);
        push_data(32'h1, 3);
        drain("ready_back");

        start = 1'b0;
        push_data(32'h4, 2);
        push_idle(2);
        drain("stop");
        start = 1'b1;
        push_idle(2);
        push_align(2);
        drain("restart");

        // Error rise during ALIGN is dropped, and holding it into DATA does nothing.
        gen_err = 1'b1;
        push_align(14);
        push_data(32'h1, 4);
        drain("align_err");
        gen_err = 1'b0;
        check_inj("align_err_inj", 16'd1);

        reset_n = 1'b0;
        push_idle(1);
        drain("rst_mid");
        check_inj("rst_mid_inj", 16'd0);
        reset_n = 1'b1;
        push_idle(2);
        push_align(16);
        push_data(32'h1, 2);
        drain("rst_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter g_DATA_WID, default 32: TX data width; only 32 is supported.
REQ-002 Parameter g_ALIGN_LEN, default 16: number of K28.5 alignment words sent before data; legal range 4..255.
REQ-003 clk_i  input  1  TX fabric clock; every register is clocked on its rising edge.
REQ-004 reset_n_i  input  1  reset, synchronous and active-low.
REQ-005 start_i  input  1  UART start level; asynchronous to clk_i.
REQ-006 clear_i  input  1  UART clear level; asynchronous to clk_i.
REQ-007 generate_err_i  input  1  UART error-inject request; asynchronous to clk_i.
REQ-008 tx_ready_i  input  1  XCVR TX lane ready.
REQ-009 tx_data_o  output  32  XCVR TX data.
REQ-010 tx_k_char_o  output  4  per-byte K-character flags.
REQ-011 tx_val_o  output  1  high while the block is in ALIGN or DATA.
REQ-012 state_o  output  2  current state: IDLE=00, ALIGN=01, DATA=10.
REQ-013 inj_count_o  output  16  count of injected errors.

Function
REQ-014 start_i, clear_i and generate_err_i shall each pass through a 2-flop synchronizer (_d1, _d2) before any use.
REQ-015 The FSM shall have three states: IDLE, ALIGN, DATA; encoding 11 is illegal and shall return to IDLE on the next edge.
REQ-016 IDLE: tx_data_o=0x000000BC, tx_k_char_o=4'b0001, tx_val_o=0.
REQ-017 IDLE->ALIGN: on an edge where start_d2=1 and tx_ready_i=1; the align counter shall be cleared to 0 on that edge.
REQ-018 ALIGN: tx_data_o=0x000000BC, tx_k_char_o=4'b0001, tx_val_o=1; the align counter shall increment once per cycle.
REQ-019 ALIGN->DATA: after exactly g_ALIGN_LEN ALIGN words; the same edge shall register tx_data_o=0x00000001 and tx_k_char_o=4'b0000.
REQ-020 DATA: tx_k_char_o=4'b0000; the data counter shall increment by 1 every cycle with no gaps.
REQ-021 Data counter wrap: 0xFFFFFFFF shall be followed by 0x00000000.
REQ-022 Any state -> IDLE: on an edge where start_d2=0 or tx_ready_i=0; IDLE output values shall appear after that same edge.
REQ-023 Re-entry from IDLE shall restart the full ALIGN sequence, and data shall restart at 0x00000001.
REQ-024 Error inject: a rising edge of generate_err_d2 while in DATA shall XOR bit 0 of the next transmitted word only.
REQ-025 An injected word shall not alter the counter sequence; the following word carries the uncorrupted next value.
REQ-026 A rising edge of generate_err_d2 in IDLE or ALIGN shall be ignored and not queued.
REQ-027 Holding generate_err_i high shall inject exactly one error.
REQ-028 inj_count_o shall increment on each injected word and saturate at 0xFFFF.
REQ-029 clear_d2=1 shall zero inj_count_o; if clear and inject occur in the same cycle, clear wins and inj_count_o=0.
REQ-030 All outputs shall be registered; state_o shall reflect the registered FSM state.

Reset
REQ-031 On an edge with reset_n_i=0: state=IDLE, tx_data_o=0x000000BC, tx_k_char_o=4'b0001, tx_val_o=0, inj_count_o=0, all counters and synchronizer flops = 0.
REQ-032 Reset asserted mid-DATA shall give IDLE outputs on the next edge, with no partial word emitted.
REQ-033 After reset release, start_i must be seen high through the synchronizer before ALIGN is entered.

Verification
REQ-034 Reset, then start_i=1 and tx_ready_i=1 with g_ALIGN_LEN=16 -> exactly 16 words of tx_val_o=1, K=0001, 0xBC, then 0x00000001, 0x00000002, ... consecutively.
REQ-035 Force the data counter to 0xFFFFFFFE -> output sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-036 Pulse generate_err_i for 10 cycles in DATA when the expected word is 0x00000064 -> one word 0x00000065 sent in place of 0x00000064, then 0x00000065, 0x00000066; inj_count_o=1.
REQ-037 Drop tx_ready_i for 1 cycle in DATA -> IDLE (state_o=00, K28.5, tx_val_o=0); on ready return, 16 ALIGN words then data restarts at 0x00000001.
REQ-038 Assert clear_i and the inject edge in the same cycle -> inj_count_o=0; a generate_err_i pulse during ALIGN -> no corrupted word and inj_count_o unchanged.
REQ-039 Loop tx outputs into the existing pattern checker for 10^5 cycles -> checker lock held and checker error count reaches 0 after alignment.
